// File: rtl/video_out_gen.sv
// Video pixel transmitter: unpacks 32-bit FIFO words into an 8-bit pixel
// stream framed by line_valid/frame_valid, with line and frame blanking.
module video_out_gen #(
    parameter int p_WIDTH  = 640,
    parameter int p_HEIGHT = 480,
    parameter int p_LSYNC  = 160,
    parameter int p_FSYNC  = 40
) (
    input  logic        clk,
    input  logic        nRST,
    input  logic        fifo_empty,
    input  logic [31:0] fifo_data,
    output logic        r_e,
    output logic        line_valid,
    output logic        frame_valid,
    output logic [7:0]  pixel_out,
    output logic        underflow
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    localparam logic [9:0] H_ACT  = 10'(p_WIDTH);
    localparam logic [9:0] V_ACT  = 10'(p_HEIGHT);
    localparam logic [9:0] H_LAST = 10'(p_WIDTH + p_LSYNC - 1);
    localparam logic [9:0] V_LAST = 10'(p_HEIGHT + p_FSYNC - 1);

    logic [0:0]  state_q, state_d;
    logic [9:0]  h_q, h_d;
    logic [9:0]  v_q, v_d;
    logic [23:0] sr_q, sr_d;
    logic        lv_q, lv_d;
    logic        fv_q, fv_d;
    logic [7:0]  pix_q, pix_d;
    logic        uf_q, uf_d;

    logic run;
    logic act;
    logic grp_start;

    assign run       = (state_q == S_RUN);
    assign act       = run && (v_q < V_ACT) && (h_q < H_ACT);
    assign grp_start = act && (h_q[1:0] == 2'd0);

    always_comb begin
        state_d = state_q;
        h_d     = h_q;
        v_d     = v_q;
        sr_d    = sr_q;
        pix_d   = 8'h00;
        uf_d    = 1'b0;
        r_e     = 1'b0;
        lv_d    = act;
        fv_d    = run && (v_q < V_ACT);

        if (!run) begin
            if (!fifo_empty) begin
                state_d = S_RUN;
            end
        end else if (h_q == H_LAST) begin
            h_d = 10'd0;
            v_d = (v_q == V_LAST) ? 10'd0 : v_q + 10'd1;
        end else begin
            h_d = h_q + 10'd1;
        end

        // An empty FIFO at a group boundary blanks all four pixels of it.
        if (grp_start) begin
            if (fifo_empty) begin
                uf_d = 1'b1;
                sr_d = 24'h0;
            end else begin
                r_e   = 1'b1;
                pix_d = fifo_data[31:24];
                sr_d  = fifo_data[23:0];
            end
        end else if (act) begin
            pix_d = sr_q[23:16];
            sr_d  = {sr_q[15:0], 8'h00};
        end
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state_q <= S_IDLE;
            h_q     <= 10'd0;
            v_q     <= 10'd0;
            sr_q    <= 24'h0;
            lv_q    <= 1'b0;
            fv_q    <= 1'b0;
            pix_q   <= 8'h00;
            uf_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            h_q     <= h_d;
            v_q     <= v_d;
            sr_q    <= sr_d;
            lv_q    <= lv_d;
            fv_q    <= fv_d;
            pix_q   <= pix_d;
            uf_q    <= uf_d;
        end
    end

    assign line_valid  = lv_q;
    assign frame_valid = fv_q;
    assign pixel_out   = pix_q;
    assign underflow   = uf_q;

endmodule

// File: tb/tb_video_out_gen.sv
// Bench for video_out_gen: directed framing/underflow/reset steps plus
// randomized data and FIFO gaps checked against a raster-position model.
module tb_video_out_gen;

    localparam int W = 8;
    localparam int H = 2;
    localparam int L = 4;
    localparam int F = 2;
    localparam int LINE  = W + L;
    localparam int FRAME = LINE * (H + F);

    logic        clk = 1'b0;
    logic        nRST;
    logic        fifo_empty;
    logic [31:0] fifo_data;
    logic        r_e;
    logic        line_valid;
    logic        frame_valid;
    logic [7:0]  pixel_out;
    logic        underflow;

    always #5 clk = ~clk;

    video_out_gen #(
        .p_WIDTH (W),
        .p_HEIGHT(H),
        .p_LSYNC (L),
        .p_FSYNC (F)
    ) dut (
        .clk        (clk),
        .nRST       (nRST),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .r_e        (r_e),
        .line_valid (line_valid),
        .frame_valid(frame_valid),
        .pixel_out  (pixel_out),
        .underflow  (underflow)
    );

    int checks = 0;
    int errors = 0;

    logic [31:0] q[$];
    bit          running = 0;
    int          t = 0;
    logic [31:0] grp = 32'h0;
    bit          force_e = 0;
    int          ncyc = 0;
    bit          prev_lv = 0;
    int          lv_rise[$];
    logic [7:0]  pix_log[$];
    int          uf_cnt = 0;
    int          pop_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        fifo_empty = (q.size() == 0) || force_e;
        fifo_data  = (q.size() != 0) ? q[0] : 32'hDEAD_BEEF;
    endtask

    // One pixel clock: t is the raster position of the current cycle.
    task automatic step();
        int          col;
        int          line;
        bit          act;
        bit          fetch;
        bit          e_re;
        bit          e_lv;
        bit          e_fv;
        bit          e_uf;
        logic [7:0]  e_pix;
        drive();
        #1;
        col   = t % LINE;
        line  = (t / LINE) % (H + F);
        act   = running && line < H && col < W;
        fetch = act && (col % 4 == 0);
        e_re  = fetch && !fifo_empty;
        chk("r_e", {31'b0, r_e}, {31'b0, e_re});
        if (fetch) grp = fifo_empty ? 32'h0 : q[0];
        e_lv  = act;
        e_fv  = running && line < H;
        e_uf  = fetch && fifo_empty;
        e_pix = act ? grp[8*(3 - col % 4) +: 8] : 8'h00;
        @(posedge clk);
        if (e_re) begin
            void'(q.pop_front());
            pop_cnt++;
        end
        if (running) t++;
        else if (!fifo_empty) begin
            running = 1;
            t = 0;
        end
        #1;
        ncyc++;
        chk("line_valid", {31'b0, line_valid}, {31'b0, e_lv});
        chk("frame_valid", {31'b0, frame_valid}, {31'b0, e_fv});
        chk("pixel_out", {24'b0, pixel_out}, {24'b0, e_pix});
        chk("underflow", {31'b0, underflow}, {31'b0, e_uf});
        if (line_valid && !prev_lv) lv_rise.push_back(ncyc);
        if (line_valid) pix_log.push_back(pixel_out);
        if (underflow) uf_cnt++;
        prev_lv = line_valid;
    endtask

    initial begin
        logic [7:0] exp_pix[8];
        int         fv_hi;
        exp_pix = '{8'hAA, 8'hBB, 8'hCC, 8'hDD,
                    8'h11, 8'h22, 8'h33, 8'h44};

        nRST = 1'b0;
        drive();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_lv", {31'b0, line_valid}, 32'd0);
        chk("rst_fv", {31'b0, frame_valid}, 32'd0);
        chk("rst_pix", {24'b0, pixel_out}, 32'd0);
        chk("rst_uf", {31'b0, underflow}, 32'd0);
        nRST = 1'b1;

        // Idle with an empty FIFO
        repeat (20) step();
        chk("idle_stays", {31'b0, running}, 32'd0);

        // Two frames: directed first words, random after
        q.push_back(32'hAABBCCDD);
        q.push_back(32'h11223344);
        q.push_back(32'h55667788);
        q.push_back(32'h99AABBCC);
        repeat (4) q.push_back($urandom);
        lv_rise.delete();
        pix_log.delete();
        pop_cnt = 0;
        fv_hi = 0;
        for (int i = 0; i < 2 * FRAME + 1; i++) begin
            step();
            if (i < FRAME + 1 && frame_valid) fv_hi++;
        end
        for (int i = 0; i < 8; i++)
            chk("line0_pix", {24'b0, pix_log[i]}, {24'b0, exp_pix[i]});
        chk("lv_rises", lv_rise.size(), 4);
        chk("line_period", lv_rise[1] - lv_rise[0], LINE);
        chk("frame_period", lv_rise[2] - lv_rise[0], FRAME);
        chk("lv_cycles", pix_log.size(), 2 * H * W);
        chk("fv_cycles", fv_hi, H * LINE);
        chk("pops_2frames", pop_cnt, 2 * W * H / 4);

        // Forced underflow at h=4 of line 0
        repeat (8) q.push_back($urandom);
        uf_cnt = 0;
        for (int i = 0; i < FRAME; i++) begin
            force_e = (t % FRAME == 4);
            step();
        end
        force_e = 0;
        chk("uf_pulses", uf_cnt, 1);

        // Random data and random FIFO gaps
        for (int i = 0; i < 4 * FRAME; i++) begin
            if ($urandom_range(0, 3) == 0) q.push_back($urandom);
            force_e = ($urandom_range(0, 5) == 0);
            step();
        end
        force_e = 0;

        // Reset in the middle of line 0
        repeat (4) q.push_back($urandom);
        for (int i = 0; i < FRAME && (t % FRAME) != 3; i++) step();
        chk("at_h3", t % FRAME, 3);
        nRST = 1'b0;
        #1;
        chk("mid_rst_lv", {31'b0, line_valid}, 32'd0);
        chk("mid_rst_fv", {31'b0, frame_valid}, 32'd0);
        chk("mid_rst_pix", {24'b0, pixel_out}, 32'd0);
        chk("mid_rst_re", {31'b0, r_e}, 32'd0);
        running = 0;
        t = 0;
        grp = 32'h0;
        prev_lv = 0;
        repeat (2) @(posedge clk);
        #2;
        nRST = 1'b1;
        lv_rise.delete();
        ncyc = 0;
        repeat (20) q.push_back($urandom);
        repeat (FRAME) step();
        chk("restart_lv", lv_rise.size() > 0 ? lv_rise[0] : -1, 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
